ps2_rx_frame: RTL and testbench
===============================

// Module: ps2_rx_frame
// PURPOSE
//  PS/2 device-to-host receiver. Sits between the raw ps2_clk/data pins and the key-decode stage.
//  Synchronises and filters ps2_clk, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
//  Folds 0xE0/0xF0 prefixes into flags. Delivers one make/break code per key event, with error reporting.
// PARAMETERS
//  FILTER_LEN   4      consecutive clk samples ps2_clk must hold a new level before the filtered level changes (>=2)
//  TIMEOUT_CYC  50000  clk cycles without a filtered falling edge mid-frame before the frame is aborted (1 ms @ 50 MHz)
//  FIFO_DEPTH   4      output FIFO entries, power of 2; used only with PS2_RX_FIFO_EN
// PORTS
//  clk         in   1  system clock; all state on posedge
//  reset       in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw PS/2 clock pin, asynchronous
//  data        in   1  raw PS/2 data pin, asynchronous
//  code_ready  in   1  consumer accepts the code (FIFO build only; ignored otherwise)
//  code        out  8  scan code with prefixes removed
//  extended    out  1  code was preceded by 0xE0
//  released    out  1  code was preceded by 0xF0 (break)
//  code_valid  out  1  code/extended/released are valid (see BEHAVIOUR)
//  frame_err   out  1  1-cycle pulse: bad start, parity, stop, or timeout
//  overrun     out  1  1-cycle pulse: code dropped because the FIFO was full (tied 0 without FIFO)
// BEHAVIOUR
//  Reset (reset=0, async): sync flops and filtered clock go to 1; state IDLE; bit count, shift register,
//   timeout counter and pending flags cleared; code=0, extended=0, released=0, code_valid=0,
//   frame_err=0, overrun=0; FIFO emptied. A partial frame in flight is discarded and never delivered.
//  Input: ps2_clk and data each pass through 2 flops. Filtered clock changes only after FILTER_LEN equal
//   samples that differ from its current value. A filtered 1->0 transition is a "fall" (1-cycle internal strobe).
//   The synced data value at the fall is the sampled bit.
//  FSM, advancing only on a fall:
//   IDLE   bit=0 -> DATA with cnt=0; bit=1 -> stay in IDLE (spurious edge, no error).
//   DATA   shift bit in LSB-first; cnt++; after the 8th bit -> PARITY.
//   PARITY store bit -> STOP.
//   STOP   good if bit=1 and XOR(8 data, parity)=1; then process the byte. Otherwise pulse frame_err. -> IDLE.
//  Timeout: in a state other than IDLE, the counter clears on every fall and otherwise increments.
//   When it reaches TIMEOUT_CYC-1: go to IDLE, pulse frame_err, clear pending flags.
//  Byte processing: 0xE0 sets ext_pend; 0xF0 sets rel_pend; neither prefix is delivered.
//   Any other byte is delivered as {ext_pend, rel_pend, byte}, and both pending flags then clear.
//   Any frame_err also clears both pending flags.
//  Latency: delivery outputs update 1 clk after the fall that carries the stop bit. frame_err has the same timing.
//  code/extended/released hold their last delivered value until the next delivery.
// CONFIGURATION
//  PS2_RX_FIFO_EN undefined:
//   - code_valid is a 1-cycle pulse per delivery.
//   - code_ready is ignored; overrun=0.
//  PS2_RX_FIFO_EN defined:
//   - Deliveries push 10-bit {extended, released, code} into a FIFO_DEPTH FIFO.
//   - Outputs show the FIFO head; code_valid = FIFO not empty.
//   - Pop on code_valid & code_ready.
//   - Push while full and no pop: the new entry is dropped and overrun pulses.
//   - Push and pop in the same cycle while full: both occur, no overrun.
//   - Empty with push: entry visible 1 clk later (no bypass).
// TESTING
//  Frames sent at a 12.5 kHz PS/2 rate, clk 50 MHz, FILTER_LEN=4, TIMEOUT_CYC=50000.
//  1. Frame 0x1C, parity 0, stop 1 -> single valid: code=0x1C, extended=0, released=0, frame_err never set.
//  2. Frames F0,1C then E0,F0,75 -> exactly two deliveries: {0,1,0x1C}, then {1,1,0x75}; no output for prefixes.
//  3. Frame 0x1C with parity 1 -> one frame_err pulse, no valid; the following good 0x29 is delivered normally.
//  4. E0, then stop after 5 data bits, idle 50000 clks -> frame_err pulse; next 0x75 delivered with extended=0.
//  5. ps2_clk glitch low for 3 clks while in IDLE with data=0 -> FSM stays IDLE; next full 0x1C frame is correct.
//  6. FIFO build, code_ready=0, send 0x16,0x1E,0x26,0x25,0x2E:
//     - overrun pulses once, on the 5th frame.
//     - Then raise code_ready: pops 0x16,0x1E,0x26,0x25 in order, then code_valid=0.

Source files
------------

// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver pin/code bundle: raw PS/2 pins in, decoded scan codes and status out.
interface ps2_rx_frame_if;
    logic       ps2_clk;
    logic       data;
    logic       code_ready;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       code_valid;
    logic       frame_err;
    logic       overrun;

    // Receiver side
    modport master (
        input  ps2_clk, data, code_ready,
        output code, extended, released, code_valid, frame_err, overrun
    );

    // Pin driver / code consumer side
    modport slave (
        output ps2_clk, data, code_ready,
        input  code, extended, released, code_valid, frame_err, overrun
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync + glitch filter on ps2_clk, 11-bit frame
// deserialiser, E0/F0 prefix folding, and code delivery with error reporting.
// Define PS2_RX_FIFO_EN to buffer deliveries in a FIFO_DEPTH-entry output FIFO
// with code_valid/code_ready handshake; otherwise code_valid is a one-cycle pulse.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    ps2_rx_frame_if.master bus
);
    localparam int unsigned FCNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);
    localparam int unsigned ENT_W  = 10;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fall_c;

    state_e            state_q, state_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              ext_q, ext_d, rel_q, rel_d;
    logic              err_d, err_q;
    logic              push_c;
    logic [ENT_W-1:0]  entry_c;

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= bus.ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock flips after FILTER_LEN consecutive samples at the opposite level
    always_comb begin
        fcnt_d = '0;
        filt_d = filt_q;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign fall_c = filt_q & ~filt_d;

    // Filter state and frame FSM registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            state_q <= IDLE;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            err_q   <= err_d;
        end
    end

    // Frame FSM: advances on filtered falls, timeout aborts a stalled frame
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = '0;
        ext_d   = ext_q;
        rel_d   = rel_q;
        err_d   = 1'b0;
        push_c  = 1'b0;

        if (state_q != IDLE && !fall_c) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (fall_c && !dat_s2_q) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_c) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    state_d = IDLE;
                    if (dat_s2_q && ((^shift_q) ^ par_q)) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_d = 1'b1;
                        end else begin
                            push_c = 1'b1;
                            ext_d  = 1'b0;
                            rel_d  = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall_c && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end
    end

    assign entry_c       = {ext_q, rel_q, shift_q};
    assign bus.frame_err = err_q;

`ifdef PS2_RX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_q, rd_q;
    logic             ovr_q;
    logic             empty_c, full_c, pop_c, wr_c;

    assign empty_c = (wr_q == rd_q);
    assign full_c  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign pop_c   = !empty_c && bus.code_ready;
    assign wr_c    = push_c && (!full_c || pop_c);

    // Output FIFO: a push into a full FIFO is dropped unless a pop frees the slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (wr_c) begin
                mem_q[wr_q[PTR_W-1:0]] <= entry_c;
                wr_q <= wr_q + (PTR_W+1)'(1);
            end
            if (pop_c) begin
                rd_q <= rd_q + (PTR_W+1)'(1);
            end
            ovr_q <= push_c && full_c && !pop_c;
        end
    end

    assign {bus.extended, bus.released, bus.code} = mem_q[rd_q[PTR_W-1:0]];
    assign bus.code_valid = !empty_c;
    assign bus.overrun    = ovr_q;
`else
    logic [ENT_W-1:0] out_q;
    logic             valid_q;
    logic             unused_ready;

    // Delivery register: holds last code, valid pulses once per delivery
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_c) begin
                out_q <= entry_c;
            end
            valid_q <= push_c;
        end
    end

    assign unused_ready = bus.code_ready;
    assign {bus.extended, bus.released, bus.code} = out_q;
    assign bus.code_valid = valid_q;
    assign bus.overrun    = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: drives PS/2 frames on the pins, keeps a queue of
// expected deliveries, and compares it against codes captured from the output.
// A faster PS/2 bit rate and shorter timeout keep the run short.
module tb_ps2_rx_frame;
    localparam int HALF = 40;
    localparam int TMO  = 1000;

    logic clk = 1'b0;
    logic reset;
    ps2_rx_frame_if bus();

    ps2_rx_frame #(.FILTER_LEN(4), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] obs_mem [64];
    int obs_n = 0;
    int obs_rd = 0;
    int err_n = 0;
    int ovr_n = 0;

    // Capture accepted codes and status pulses away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            if (bus.code_valid && bus.code_ready && obs_n < 64) begin
                obs_mem[obs_n] <= {bus.extended, bus.released, bus.code};
                obs_n <= obs_n + 1;
            end
            if (bus.frame_err) err_n <= err_n + 1;
            if (bus.overrun)   ovr_n <= ovr_n + 1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.data = b;
        wait_clks(HALF);
        bus.ps2_clk = 1'b0;
        wait_clks(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    // Start bit, nbits data bits LSB-first; full frames add odd parity and stop
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(b[i]);
        if (nbits == 8) begin
            send_bit((~^b) ^ bad_par);
            send_bit(1'b1);
        end
        bus.data = 1'b1;
        wait_clks(2 * HALF);
    endtask

    // Compare captured deliveries against the expected queue
    task automatic drain(input string tag);
        check({tag, " count"}, 32'(obs_n - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            check(tag, 32'(obs_mem[obs_rd]), 32'(exp_q.pop_front()));
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_n;
    endtask

    initial begin
        reset = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.data = 1'b1;
        bus.code_ready = 1'b1;
        wait_clks(5);
        check("rst code", 32'(bus.code), 32'h0);
        check("rst ext_rel", 32'({bus.extended, bus.released}), 32'h0);
        check("rst valid", 32'(bus.code_valid), 32'h0);
        check("rst err_ovr", 32'({bus.frame_err, bus.overrun}), 32'h0);
        reset = 1'b1;
        wait_clks(5);

        // Single plain make code
        send_frame(8'h1C, 1'b0, 8);
        exp_q.push_back({2'b00, 8'h1C});
        drain("t1 code");
        check("t1 err", 32'(err_n), 32'd0);
`ifndef PS2_RX_FIFO_EN
        check("t1 hold code", 32'(bus.code), 32'h1C);
        check("t1 valid pulse", 32'(bus.code_valid), 32'h0);
`endif

        // Break, then extended break; prefixes not delivered
        send_frame(8'hF0, 1'b0, 8);
        send_frame(8'h1C, 1'b0, 8);
        send_frame(8'hE0, 1'b0, 8);
        send_frame(8'hF0, 1'b0, 8);
        send_frame(8'h75, 1'b0, 8);
        exp_q.push_back({2'b01, 8'h1C});
        exp_q.push_back({2'b11, 8'h75});
        drain("t2 code");
`ifndef PS2_RX_FIFO_EN
        check("t2 hold flags", 32'({bus.extended, bus.released}), 32'h3);
`endif

        // Parity error, then normal frame
        send_frame(8'h1C, 1'b1, 8);
        check("t3 err", 32'(err_n), 32'd1);
        send_frame(8'h29, 1'b0, 8);
        exp_q.push_back({2'b00, 8'h29});
        drain("t3 code");

        // Prefix, truncated frame times out and clears pending extended flag
        send_frame(8'hE0, 1'b0, 8);
        send_frame(8'h75, 1'b0, 5);
        wait_clks(TMO + 200);
        check("t4 timeout err", 32'(err_n), 32'd2);
        send_frame(8'h75, 1'b0, 8);
        exp_q.push_back({2'b00, 8'h75});
        drain("t4 code");

        // Short ps2_clk glitch in IDLE must be filtered out
        bus.data = 1'b0;
        wait_clks(10);
        bus.ps2_clk = 1'b0;
        wait_clks(3);
        bus.ps2_clk = 1'b1;
        wait_clks(20);
        bus.data = 1'b1;
        wait_clks(2 * HALF);
        send_frame(8'h1C, 1'b0, 8);
        exp_q.push_back({2'b00, 8'h1C});
        drain("t5 code");
        check("t5 err", 32'(err_n), 32'd2);

`ifdef PS2_RX_FIFO_EN
        // FIFO fills with consumer stalled; fifth entry overruns
        bus.code_ready = 1'b0;
        send_frame(8'h16, 1'b0, 8);
        send_frame(8'h1E, 1'b0, 8);
        send_frame(8'h26, 1'b0, 8);
        send_frame(8'h25, 1'b0, 8);
        check("t6 ovr before", 32'(ovr_n), 32'd0);
        check("t6 valid full", 32'(bus.code_valid), 32'h1);
        check("t6 head", 32'(bus.code), 32'h16);
        send_frame(8'h2E, 1'b0, 8);
        check("t6 ovr after", 32'(ovr_n), 32'd1);
        exp_q.push_back({2'b00, 8'h16});
        exp_q.push_back({2'b00, 8'h1E});
        exp_q.push_back({2'b00, 8'h26});
        exp_q.push_back({2'b00, 8'h25});
        bus.code_ready = 1'b1;
        wait_clks(10);
        drain("t6 pop");
        check("t6 empty", 32'(bus.code_valid), 32'h0);
`else
        check("no overrun", 32'(ovr_n), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
